core_bus_arbiter: RTL and testbench

- Two-to-one arbiter for Ibex-style req/gnt/rvalid memory ports.
- Merges the core's instruction fetch port (host 0) and data LSU port (host 1) onto one downstream port that feeds a single tlul_host_adapter.
- One TL-UL host channel therefore serves both core interfaces.
- Arbitrates round-robin, holds a winner stable until granted, limits outstanding transactions, and routes each in-order response back to the host that issued it.

---
 rtl/core_bus_arbiter.sv | 133 +++++++++++++
 tb/tb_core_bus_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_bus_arbiter.sv
// Round-robin 2:1 arbiter merging the core's fetch (host 0) and LSU (host 1) req/gnt/rvalid ports
// onto a single downstream port, routing in-order responses back through a small ID FIFO.
module core_bus_arbiter #(
  parameter int unsigned MAX_OUTST = 2,
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32
) (
  input  logic            clock,
  input  logic            rst_ni,
  input  logic            h0_req_i,
  output logic            h0_gnt_o,
  input  logic [AW-1:0]   h0_addr_i,
  input  logic            h0_we_i,
  input  logic [DW/8-1:0] h0_be_i,
  input  logic [DW-1:0]   h0_wdata_i,
  output logic            h0_rvalid_o,
  output logic [DW-1:0]   h0_rdata_o,
  output logic            h0_err_o,
  input  logic            h1_req_i,
  output logic            h1_gnt_o,
  input  logic [AW-1:0]   h1_addr_i,
  input  logic            h1_we_i,
  input  logic [DW/8-1:0] h1_be_i,
  input  logic [DW-1:0]   h1_wdata_i,
  output logic            h1_rvalid_o,
  output logic [DW-1:0]   h1_rdata_o,
  output logic            h1_err_o,
  output logic            dev_req_o,
  input  logic            dev_gnt_i,
  output logic [AW-1:0]   dev_addr_o,
  output logic            dev_we_o,
  output logic [DW/8-1:0] dev_be_o,
  output logic [DW-1:0]   dev_wdata_o,
  input  logic            dev_rvalid_i,
  input  logic [DW-1:0]   dev_rdata_i,
  input  logic            dev_err_i,
  output logic            unexp_rsp_o
);

  localparam int unsigned PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int unsigned CW = $clog2(MAX_OUTST + 1);

  logic                 lock_q, lock_d;
  logic                 owner_q, owner_d;
  logic                 rr_q, rr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [PW-1:0]        wptr_q, wptr_d;
  logic [PW-1:0]        rptr_q, rptr_d;
  logic                 unexp_q, unexp_d;
  logic [MAX_OUTST-1:0] id_mem_q;

  logic winner, win_req, full, cnt_nz, accept, pop, head;

  assign full   = (cnt_q == CW'(MAX_OUTST));
  assign cnt_nz = (cnt_q != '0);

  // A locked owner keeps the port until granted; otherwise a tie goes to rr_q.
  always_comb begin
    winner = 1'b0;
    if (lock_q)                     winner = owner_q;
    else if (h0_req_i && h1_req_i)  winner = rr_q;
    else if (h1_req_i)              winner = 1'b1;
  end

  assign win_req     = winner ? h1_req_i   : h0_req_i;
  assign dev_req_o   = win_req & ~full;
  assign dev_addr_o  = winner ? h1_addr_i  : h0_addr_i;
  assign dev_we_o    = winner ? h1_we_i    : h0_we_i;
  assign dev_be_o    = winner ? h1_be_i    : h0_be_i;
  assign dev_wdata_o = winner ? h1_wdata_i : h0_wdata_i;

  assign accept   = dev_req_o & dev_gnt_i;
  assign h0_gnt_o = accept & ~winner;
  assign h1_gnt_o = accept &  winner;

  assign pop         = dev_rvalid_i & cnt_nz;
  assign head        = id_mem_q[rptr_q];
  assign h0_rvalid_o = pop & ~head;
  assign h1_rvalid_o = pop &  head;
  assign h0_rdata_o  = dev_rdata_i;
  assign h1_rdata_o  = dev_rdata_i;
  assign h0_err_o    = dev_err_i;
  assign h1_err_o    = dev_err_i;
  assign unexp_rsp_o = unexp_q;

  always_comb begin
    lock_d  = lock_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    cnt_d   = cnt_q;
    unexp_d = unexp_q;
    if (accept) begin
      lock_d = 1'b0;
      rr_d   = ~winner;
      wptr_d = wptr_q + 1'b1;
    end else if (dev_req_o) begin
      lock_d  = 1'b1;
      owner_d = winner;
    end
    if (pop) rptr_d = rptr_q + 1'b1;
    if (accept && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!accept && pop) cnt_d = cnt_q - 1'b1;
    if (dev_rvalid_i && !cnt_nz) unexp_d = 1'b1;
  end

  always_ff @(posedge clock or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q  <= 1'b0;
      owner_q <= 1'b0;
      rr_q    <= 1'b1;
      cnt_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      unexp_q <= 1'b0;
    end else begin
      lock_q  <= lock_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      unexp_q <= unexp_d;
    end
  end

  // Entries are only read while cnt_q is non-zero, so their contents need no reset.
  always_ff @(posedge clock) begin
    if (accept) id_mem_q[wptr_q] <= winner;
  end

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Directed bench for core_bus_arbiter: a queue-based reference model checked every cycle,
// plus literal expectations for each scenario.
module tb_core_bus_arbiter;

  localparam int MO = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clock = 1'b0;
  logic            rst_ni = 1'b0;
  logic            h0_req_i = 1'b0, h1_req_i = 1'b0;
  logic            h0_gnt_o, h1_gnt_o;
  logic [AW-1:0]   h0_addr_i = '0, h1_addr_i = '0;
  logic            h0_we_i = 1'b0, h1_we_i = 1'b0;
  logic [DW/8-1:0] h0_be_i = '0, h1_be_i = '0;
  logic [DW-1:0]   h0_wdata_i = '0, h1_wdata_i = '0;
  logic            h0_rvalid_o, h1_rvalid_o;
  logic [DW-1:0]   h0_rdata_o, h1_rdata_o;
  logic            h0_err_o, h1_err_o;
  logic            dev_req_o;
  logic            dev_gnt_i = 1'b0;
  logic [AW-1:0]   dev_addr_o;
  logic            dev_we_o;
  logic [DW/8-1:0] dev_be_o;
  logic [DW-1:0]   dev_wdata_o;
  logic            dev_rvalid_i = 1'b0;
  logic [DW-1:0]   dev_rdata_i = '0;
  logic            dev_err_i = 1'b0;
  logic            unexp_rsp_o;

  core_bus_arbiter #(.MAX_OUTST(MO), .AW(AW), .DW(DW)) dut (
    .clock(clock), .rst_ni(rst_ni),
    .h0_req_i(h0_req_i), .h0_gnt_o(h0_gnt_o), .h0_addr_i(h0_addr_i), .h0_we_i(h0_we_i),
    .h0_be_i(h0_be_i), .h0_wdata_i(h0_wdata_i), .h0_rvalid_o(h0_rvalid_o),
    .h0_rdata_o(h0_rdata_o), .h0_err_o(h0_err_o),
    .h1_req_i(h1_req_i), .h1_gnt_o(h1_gnt_o), .h1_addr_i(h1_addr_i), .h1_we_i(h1_we_i),
    .h1_be_i(h1_be_i), .h1_wdata_i(h1_wdata_i), .h1_rvalid_o(h1_rvalid_o),
    .h1_rdata_o(h1_rdata_o), .h1_err_o(h1_err_o),
    .dev_req_o(dev_req_o), .dev_gnt_i(dev_gnt_i), .dev_addr_o(dev_addr_o), .dev_we_o(dev_we_o),
    .dev_be_o(dev_be_o), .dev_wdata_o(dev_wdata_o), .dev_rvalid_i(dev_rvalid_i),
    .dev_rdata_i(dev_rdata_i), .dev_err_i(dev_err_i), .unexp_rsp_o(unexp_rsp_o)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of hosts owed a response, the host holding a stalled request
  // (-1 if none), and the last host granted (the other one wins a tie).
  int q[$];
  int held = -1;
  int last = 0;
  bit unexp_m = 1'b0;

  function automatic bit req_of(input int h);
    return (h == 1) ? h1_req_i : h0_req_i;
  endfunction

  function automatic int pick_w();
    if (held >= 0) return held;
    if (h0_req_i && !h1_req_i) return 0;
    if (h1_req_i && !h0_req_i) return 1;
    if (h0_req_i && h1_req_i) return 1 - last;
    return 0;
  endfunction

  int mw;
  bit mdr;
  bit mpop;
  initial forever begin
    @(posedge clock or negedge rst_ni);
    if (!rst_ni) begin
      q.delete();
      held = -1;
      last = 0;
      unexp_m = 1'b0;
    end else begin
      mw   = pick_w();
      mdr  = req_of(mw) && (q.size() < MO);
      mpop = dev_rvalid_i && (q.size() > 0);
      if (dev_rvalid_i && q.size() == 0) unexp_m = 1'b1;
      if (mpop) void'(q.pop_front());
      if (mdr && dev_gnt_i) begin
        q.push_back(mw);
        last = mw;
        held = -1;
      end else if (mdr) begin
        held = mw;
      end
    end
  end

  int cw;
  bit cdr;
  initial forever begin
    @(negedge clock);
    cw  = pick_w();
    cdr = req_of(cw) && (q.size() < MO);
    if (held >= 0 && !req_of(held)) chk("protocol_locked_req_dropped", 1, 0);
    chk("m_dev_req", dev_req_o, cdr);
    chk("m_dev_addr", dev_addr_o, (cw == 1) ? h1_addr_i : h0_addr_i);
    chk("m_dev_we", dev_we_o, (cw == 1) ? h1_we_i : h0_we_i);
    chk("m_dev_be", dev_be_o, (cw == 1) ? h1_be_i : h0_be_i);
    chk("m_dev_wdata", dev_wdata_o, (cw == 1) ? h1_wdata_i : h0_wdata_i);
    chk("m_h0_gnt", h0_gnt_o, cdr && dev_gnt_i && cw == 0);
    chk("m_h1_gnt", h1_gnt_o, cdr && dev_gnt_i && cw == 1);
    chk("m_h0_rvalid", h0_rvalid_o, dev_rvalid_i && q.size() > 0 && q[0] == 0);
    chk("m_h1_rvalid", h1_rvalid_o, dev_rvalid_i && q.size() > 0 && q[0] == 1);
    chk("m_h0_rdata", h0_rdata_o, dev_rdata_i);
    chk("m_h1_rdata", h1_rdata_o, dev_rdata_i);
    chk("m_h0_err", h0_err_o, dev_err_i);
    chk("m_h1_err", h1_err_o, dev_err_i);
    chk("m_unexp", unexp_rsp_o, unexp_m);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic neg();
    @(negedge clock);
  endtask

  initial begin
    repeat (2) neg();
    chk("rst_dev_req", dev_req_o, 0);
    chk("rst_h0_gnt", h0_gnt_o, 0);
    chk("rst_h1_gnt", h1_gnt_o, 0);
    chk("rst_h0_rvalid", h0_rvalid_o, 0);
    chk("rst_h1_rvalid", h1_rvalid_o, 0);
    chk("rst_unexp", unexp_rsp_o, 0);
    chk("rst_dev_addr", dev_addr_o, 0);
    step();
    rst_ni = 1'b1;

    // Single host read
    h1_req_i = 1; h1_addr_i = 32'h100; dev_gnt_i = 1;
    neg();
    chk("t1_h1_gnt", h1_gnt_o, 1);
    chk("t1_h0_gnt", h0_gnt_o, 0);
    chk("t1_dev_req", dev_req_o, 1);
    chk("t1_dev_addr", dev_addr_o, 32'h100);
    step();
    h1_req_i = 0; h1_addr_i = 0; dev_gnt_i = 0;
    step();
    dev_rvalid_i = 1; dev_rdata_i = 32'hDEADBEEF;
    neg();
    chk("t1_h1_rvalid", h1_rvalid_o, 1);
    chk("t1_h1_rdata", h1_rdata_o, 32'hDEADBEEF);
    chk("t1_h0_rvalid", h0_rvalid_o, 0);
    step();
    dev_rvalid_i = 0; dev_rdata_i = 0;

    // Round-robin from reset, with the full condition
    rst_ni = 0;
    step();
    rst_ni = 1;
    h0_req_i = 1; h1_req_i = 1; h0_addr_i = 32'h10; h1_addr_i = 32'h20; dev_gnt_i = 1;
    neg();
    chk("t2_c1_h1_gnt", h1_gnt_o, 1);
    chk("t2_c1_h0_gnt", h0_gnt_o, 0);
    chk("t2_c1_addr", dev_addr_o, 32'h20);
    step();
    neg();
    chk("t2_c2_h0_gnt", h0_gnt_o, 1);
    chk("t2_c2_h1_gnt", h1_gnt_o, 0);
    chk("t2_c2_addr", dev_addr_o, 32'h10);
    step();
    dev_rvalid_i = 1;
    neg();
    chk("t2_full_dev_req", dev_req_o, 0);
    chk("t2_full_h0_gnt", h0_gnt_o, 0);
    chk("t2_full_h1_gnt", h1_gnt_o, 0);
    chk("t2_full_h1_rvalid", h1_rvalid_o, 1);
    step();
    neg();
    chk("t2_c4_dev_req", dev_req_o, 1);
    chk("t2_c4_h1_gnt", h1_gnt_o, 1);
    chk("t2_c4_h0_rvalid", h0_rvalid_o, 1);
    step();
    dev_rvalid_i = 0;
    neg();
    chk("t2_c5_h0_gnt", h0_gnt_o, 1);
    step();
    h0_req_i = 0; h1_req_i = 0; dev_gnt_i = 0; dev_rvalid_i = 1;
    neg();
    chk("t2_drain_h1", h1_rvalid_o, 1);
    step();
    neg();
    chk("t2_drain_h0", h0_rvalid_o, 1);
    step();
    dev_rvalid_i = 0;

    // Lock stability while the downstream stalls
    h0_req_i = 1; h1_req_i = 1; h0_addr_i = 32'hA0; h1_addr_i = 32'hB0; dev_gnt_i = 0;
    for (int i = 0; i < 3; i++) begin
      neg();
      chk("t3_lock_addr", dev_addr_o, 32'hB0);
      chk("t3_lock_req", dev_req_o, 1);
      chk("t3_lock_h1_gnt", h1_gnt_o, 0);
      step();
    end
    dev_gnt_i = 1;
    neg();
    chk("t3_h1_gnt", h1_gnt_o, 1);
    chk("t3_h0_gnt", h0_gnt_o, 0);
    step();
    neg();
    chk("t3_next_h0_gnt", h0_gnt_o, 1);
    chk("t3_next_addr", dev_addr_o, 32'hA0);
    step();
    h0_req_i = 0; h1_req_i = 0; dev_gnt_i = 0; dev_rvalid_i = 1;
    neg();
    chk("t3_drain_h1", h1_rvalid_o, 1);
    step();
    neg();
    chk("t3_drain_h0", h0_rvalid_o, 1);
    step();
    dev_rvalid_i = 0;

    // Response ordering with write fields and error
    h0_req_i = 1; h0_addr_i = 32'h80; h0_we_i = 0; dev_gnt_i = 1;
    neg();
    chk("t4_h0_gnt", h0_gnt_o, 1);
    chk("t4_addr0", dev_addr_o, 32'h80);
    chk("t4_we0", dev_we_o, 0);
    step();
    h0_req_i = 0; h0_addr_i = 0;
    h1_req_i = 1; h1_addr_i = 32'h200; h1_we_i = 1; h1_be_i = 4'h3; h1_wdata_i = 32'h1234;
    neg();
    chk("t4_h1_gnt", h1_gnt_o, 1);
    chk("t4_addr1", dev_addr_o, 32'h200);
    chk("t4_we1", dev_we_o, 1);
    chk("t4_be1", dev_be_o, 4'h3);
    chk("t4_wdata1", dev_wdata_o, 32'h1234);
    step();
    h1_req_i = 0; h1_addr_i = 0; h1_we_i = 0; h1_be_i = 0; h1_wdata_i = 0; dev_gnt_i = 0;
    dev_rvalid_i = 1; dev_err_i = 0;
    neg();
    chk("t4_r0_h0_rvalid", h0_rvalid_o, 1);
    chk("t4_r0_h1_rvalid", h1_rvalid_o, 0);
    chk("t4_r0_h0_err", h0_err_o, 0);
    step();
    dev_err_i = 1;
    neg();
    chk("t4_r1_h1_rvalid", h1_rvalid_o, 1);
    chk("t4_r1_h0_rvalid", h0_rvalid_o, 0);
    chk("t4_r1_h1_err", h1_err_o, 1);
    step();
    dev_rvalid_i = 0; dev_err_i = 0;

    // Reset with a transaction in flight
    h0_req_i = 1; h0_addr_i = 32'h40; dev_gnt_i = 1;
    neg();
    chk("t5_h0_gnt", h0_gnt_o, 1);
    step();
    h0_req_i = 0; h0_addr_i = 0; dev_gnt_i = 0;
    step();
    rst_ni = 0; dev_rvalid_i = 1;
    #1;
    chk("t5_async_h0_rvalid", h0_rvalid_o, 0);
    chk("t5_async_dev_req", dev_req_o, 0);
    chk("t5_async_unexp", unexp_rsp_o, 0);
    neg();
    step();
    rst_ni = 1; dev_rvalid_i = 1;
    neg();
    chk("t5_late_h0_rvalid", h0_rvalid_o, 0);
    chk("t5_late_h1_rvalid", h1_rvalid_o, 0);
    step();
    dev_rvalid_i = 0;
    neg();
    chk("t5_unexp_set", unexp_rsp_o, 1);
    step();
    neg();
    chk("t5_unexp_sticky", unexp_rsp_o, 1);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
